// File: rtl/txt_vram_blit_master_pkg.sv
// Shared definitions for the VRAM blit master: bus handshake codes, opcode
// encodings, FSM states and small helpers.
package txt_vram_blit_master_pkg;

  localparam logic [1:0] UMEM_OK_READY = 2'd0;
  localparam logic [1:0] UMEM_OK_OK    = 2'd1;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'd2;
  localparam logic [1:0] UMEM_OK_FAULT = 2'd3;

  localparam logic [2:0] OPM_SIZE_QW = 3'b011;
  localparam int         OPM_WR_BIT  = 4;
  localparam int         OPM_OE_BIT  = 3;

  localparam logic [4:0] OPM_QW_RD = (5'd1 << OPM_OE_BIT) | {2'b00, OPM_SIZE_QW};
  localparam logic [4:0] OPM_QW_WR = (5'd1 << OPM_WR_BIT) | {2'b00, OPM_SIZE_QW};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_REL,
    ST_WR_REQ,
    ST_WR_REL,
    ST_DONE
  } blit_state_t;

  // Qword stride with natural 32-bit wrap in either direction.
  function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic desc);
    return desc ? (addr - 32'd8) : (addr + 32'd8);
  endfunction

  // Timeout counter width: wide enough for the limit, never below 10 bits.
  function automatic int tmo_width(input int cyc);
    return ($clog2(cyc + 1) > 10) ? $clog2(cyc + 1) : 10;
  endfunction

endpackage

// File: rtl/txt_vram_blit_master_if.sv
// MMIO bus between the blit master (initiator) and the text/framebuffer slave.
interface txt_vram_blit_master_if;
  logic [31:0] busAddr;
  logic [63:0] busOutData;
  logic [63:0] busInData;
  logic [4:0]  busOpm;
  logic [1:0]  busOK;

  modport master (
    output busAddr, busOutData, busOpm,
    input  busInData, busOK
  );

  modport slave (
    input  busAddr, busOutData, busOpm,
    output busInData, busOK
  );
endinterface

// File: rtl/txt_blit_tmo.sv
// Bus-wait timeout counter for the blit master; only present when
// TXTBLIT_TIMEOUT_EN is defined.
`ifdef TXTBLIT_TIMEOUT_EN
module txt_blit_tmo
  import txt_vram_blit_master_pkg::*;
#(
  parameter int TMO_CYC = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic count,
  input  logic clear,
  output logic expire
);
  localparam int W = tmo_width(TMO_CYC);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_reg <= '0;
    end else if (count && !expire) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  // Fires on the TMO_CYC-th cycle spent in the same wait state.
  assign expire = (cnt_reg == W'(TMO_CYC - 1));
endmodule
`endif

// File: rtl/txt_vram_blit_master.sv
// Qword fill/copy bus initiator for text VRAM. Define TXTBLIT_TIMEOUT_EN to
// abort a transfer whose slave never answers within TMO_CYC cycles.
module txt_vram_blit_master
  import txt_vram_blit_master_pkg::*;
#(
  parameter int CNT_W = 16
`ifdef TXTBLIT_TIMEOUT_EN
  , parameter int TMO_CYC = 1023
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic             cmdCopy,
  input  logic             cmdDesc,
  input  logic [31:0]      cmdSrc,
  input  logic [31:0]      cmdDst,
  input  logic [CNT_W-1:0] cmdCount,
  input  logic [63:0]      cmdPattern,
  output logic             busy,
  output logic             donePulse,
  output logic             errFault,
  txt_vram_blit_master_if.master bus
);

  blit_state_t      state_reg, state_next;
  logic [31:0]      src_reg, src_next;
  logic [31:0]      dst_reg, dst_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [63:0]      pattern_reg, pattern_next;
  logic [63:0]      data_reg, data_next;
  logic             copy_reg, copy_next;
  logic             desc_reg, desc_next;
  logic             err_reg, err_next;

  logic [31:0] addr_out;
  logic [63:0] wdata_out;
  logic [4:0]  opm_out;

`ifdef TXTBLIT_TIMEOUT_EN
  logic tmo_run;
  logic tmo_expire;

  assign tmo_run = (state_reg == ST_RD_REQ) || (state_reg == ST_RD_REL) ||
                   (state_reg == ST_WR_REQ) || (state_reg == ST_WR_REL);

  txt_blit_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clock  (clock),
    .reset  (reset),
    .count  (tmo_run),
    .clear  (state_next != state_reg),
    .expire (tmo_expire)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      src_reg     <= '0;
      dst_reg     <= '0;
      count_reg   <= '0;
      pattern_reg <= '0;
      data_reg    <= '0;
      copy_reg    <= 1'b0;
      desc_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      src_reg     <= src_next;
      dst_reg     <= dst_next;
      count_reg   <= count_next;
      pattern_reg <= pattern_next;
      data_reg    <= data_next;
      copy_reg    <= copy_next;
      desc_reg    <= desc_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    src_next     = src_reg;
    dst_next     = dst_reg;
    count_next   = count_reg;
    pattern_next = pattern_reg;
    data_next    = data_reg;
    copy_next    = copy_reg;
    desc_next    = desc_reg;
    err_next     = err_reg;
    addr_out     = '0;
    wdata_out    = '0;
    opm_out      = '0;

    case (state_reg)
      ST_IDLE: begin
        if (cmdValid) begin
          src_next     = cmdSrc & ~32'h7;
          dst_next     = cmdDst & ~32'h7;
          count_next   = cmdCount;
          pattern_next = cmdPattern;
          copy_next    = cmdCopy;
          desc_next    = cmdDesc;
          err_next     = 1'b0;
          if (cmdCount == '0)   state_next = ST_DONE;
          else if (cmdCopy)     state_next = ST_RD_REQ;
          else                  state_next = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        addr_out = src_reg;
        opm_out  = OPM_QW_RD;
        case (bus.busOK)
          UMEM_OK_OK: begin
            data_next  = bus.busInData;
            state_next = ST_RD_REL;
          end
          UMEM_OK_FAULT: begin
            err_next   = 1'b1;
            state_next = ST_DONE;
          end
          UMEM_OK_READY, UMEM_OK_HOLD: ;
        endcase
      end
      ST_RD_REL: begin
        if (bus.busOK == UMEM_OK_READY) state_next = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        addr_out  = dst_reg;
        wdata_out = copy_reg ? data_reg : pattern_reg;
        opm_out   = OPM_QW_WR;
        case (bus.busOK)
          UMEM_OK_OK:    state_next = ST_WR_REL;
          UMEM_OK_FAULT: begin
            err_next   = 1'b1;
            state_next = ST_DONE;
          end
          UMEM_OK_READY, UMEM_OK_HOLD: ;
        endcase
      end
      ST_WR_REL: begin
        // Pointers only advance once the slave has released the write.
        if (bus.busOK == UMEM_OK_READY) begin
          count_next = count_reg - CNT_W'(1);
          src_next   = step_addr(src_reg, desc_reg);
          dst_next   = step_addr(dst_reg, desc_reg);
          if (count_reg == CNT_W'(1)) state_next = ST_DONE;
          else if (copy_reg)          state_next = ST_RD_REQ;
          else                        state_next = ST_WR_REQ;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

`ifdef TXTBLIT_TIMEOUT_EN
    if (tmo_run && tmo_expire && (state_next == state_reg)) begin
      err_next   = 1'b1;
      state_next = ST_DONE;
    end
`endif
  end

  assign cmdReady       = (state_reg == ST_IDLE);
  assign busy           = (state_reg != ST_IDLE);
  assign donePulse      = (state_reg == ST_DONE);
  assign errFault       = err_reg;
  assign bus.busAddr    = addr_out;
  assign bus.busOutData = wdata_out;
  assign bus.busOpm     = opm_out;

endmodule

// File: tb/tb_txt_vram_blit_master.sv
// Self-checking bench for txt_vram_blit_master: table of commands against a
// scoreboarded slave model, plus reset-abort and (optional) timeout sequences.
module tb_txt_vram_blit_master;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cmdValid = 1'b0;
  logic             cmdReady;
  logic             cmdCopy = 1'b0;
  logic             cmdDesc = 1'b0;
  logic [31:0]      cmdSrc = '0;
  logic [31:0]      cmdDst = '0;
  logic [CNT_W-1:0] cmdCount = '0;
  logic [63:0]      cmdPattern = '0;
  logic             busy;
  logic             donePulse;
  logic             errFault;

  always #5 clock = ~clock;

  txt_vram_blit_master_if bus ();

  txt_vram_blit_master #(
    .CNT_W(CNT_W)
`ifdef TXTBLIT_TIMEOUT_EN
    , .TMO_CYC(16)
`endif
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmdValid   (cmdValid),
    .cmdReady   (cmdReady),
    .cmdCopy    (cmdCopy),
    .cmdDesc    (cmdDesc),
    .cmdSrc     (cmdSrc),
    .cmdDst     (cmdDst),
    .cmdCount   (cmdCount),
    .cmdPattern (cmdPattern),
    .busy       (busy),
    .donePulse  (donePulse),
    .errFault   (errFault),
    .bus        (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    bit          copy;
    bit          desc;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] count;
    logic [63:0] pattern;
    int          hold;
    int          fault_wr;
    bit          err;
    int          lat;
  } cmd_vec_t;

  exp_t        exp_q[$];
  logic [63:0] slv_mem[logic [31:0]];
  logic [63:0] ref_mem[logic [31:0]];

  int          hold_n   = 0;
  int          fault_wr = -1;
  int          wr_seen  = 0;
  int          hold_cnt = 0;
  bit          prev_ack = 1'b0;
  int          done_cnt = 0;
  logic [4:0]  first_opm;
  logic [31:0] first_addr;

  function automatic logic [63:0] init_val(input logic [31:0] a);
    return {a ^ 32'h5a5a_0000, ~a};
  endfunction

  function automatic logic [63:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
  endfunction

  function automatic logic [63:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic score_txn(input bit wr);
    exp_t e;
    $display("txn %s addr=%08h data=%016h opm=%02h", wr ? "WR" : "RD", bus.busAddr,
             wr ? bus.busOutData : bus.busInData, bus.busOpm);
    if (exp_q.size() == 0) begin
      check("txn_queue_depth", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check("txn_opm", 64'(bus.busOpm), e.wr ? 64'h13 : 64'h0B);
      check("txn_addr", 64'(bus.busAddr), 64'(e.addr));
      if (e.wr) check("txn_data", bus.busOutData, e.data);
    end
  endtask

  // Slave model: answers at the negative edge so the DUT sees busOK on the next posedge.
  always @(negedge clock) begin
    if (reset) begin
      bus.busOK     = 2'd0;
      bus.busInData = '0;
      hold_cnt      = 0;
      prev_ack      = 1'b0;
    end else if (bus.busOpm == 5'd0) begin
      bus.busOK = 2'd0;
      hold_cnt  = 0;
      prev_ack  = 1'b0;
    end else begin
      if (prev_ack) check("opm_release", 64'(bus.busOpm), 64'd0);
      prev_ack = 1'b0;
      if (hold_cnt == 0) begin
        first_opm  = bus.busOpm;
        first_addr = bus.busAddr;
      end else begin
        check("opm_stable", 64'(bus.busOpm), 64'(first_opm));
        check("addr_stable", 64'(bus.busAddr), 64'(first_addr));
      end
      if (hold_cnt < hold_n) begin
        bus.busOK = 2'd2;
        hold_cnt++;
      end else begin
        hold_cnt = 0;
        prev_ack = 1'b1;
        if (bus.busOpm[4]) begin
          if (wr_seen == fault_wr) begin
            bus.busOK = 2'd3;
            $display("txn WR addr=%08h answered with bus fault", bus.busAddr);
          end else begin
            bus.busOK = 2'd1;
            slv_mem[bus.busAddr] = bus.busOutData;
            score_txn(1'b1);
          end
          wr_seen++;
        end else begin
          bus.busOK     = 2'd1;
          bus.busInData = slv_rd(bus.busAddr);
          score_txn(1'b0);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (donePulse) done_cnt++;
  end

  task automatic build_expect(input cmd_vec_t v);
    logic [31:0] s;
    logic [31:0] d;
    logic [63:0] val;
    int          w;
    s = v.src & ~32'h7;
    d = v.dst & ~32'h7;
    w = 0;
    for (int i = 0; i < int'(v.count); i++) begin
      if (v.copy) begin
        val = ref_rd(s);
        exp_q.push_back('{1'b0, s, val});
      end else begin
        val = v.pattern;
      end
      if (w == v.fault_wr) break;
      exp_q.push_back('{1'b1, d, val});
      ref_mem[d] = val;
      w++;
      s = v.desc ? s - 32'd8 : s + 32'd8;
      d = v.desc ? d - 32'd8 : d + 32'd8;
    end
  endtask

  task automatic run_cmd(input int idx, input cmd_vec_t v);
    int lat;
    hold_n   = v.hold;
    fault_wr = v.fault_wr;
    wr_seen  = 0;
    build_expect(v);
    @(negedge clock);
    done_cnt   = 0;
    cmdCopy    = v.copy;
    cmdDesc    = v.desc;
    cmdSrc     = v.src;
    cmdDst     = v.dst;
    cmdCount   = v.count;
    cmdPattern = v.pattern;
    cmdValid   = 1'b1;
    @(posedge clock);
    #1;
    check("accept_ready_low", 64'(cmdReady), 64'd0);
    check("accept_err_clear", 64'(errFault), 64'd0);
    // A second offer while busy must be ignored.
    cmdDst   = 32'hDEAD_0000;
    cmdCount = 16'd7;
    lat = 1;
    while (!donePulse && lat < 3000) begin
      @(posedge clock);
      #1;
      if (lat == 1) cmdValid = 1'b0;
      lat++;
    end
    if (cmdValid) begin
      @(posedge clock);
      #1;
      cmdValid = 1'b0;
    end
    check("done_latency", 64'(lat), 64'(v.lat));
    repeat (3) @(posedge clock);
    #1;
    check("done_once", 64'(done_cnt), 64'd1);
    check("err_fault", 64'(errFault), 64'(v.err));
    check("txn_leftover", 64'(exp_q.size()), 64'd0);
    check("idle_ready", 64'(cmdReady), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    $display("cmd %0d copy=%0d desc=%0d count=%0d latency=%0d errFault=%0d", idx, v.copy, v.desc,
             v.count, lat, errFault);
    exp_q.delete();
  endtask

  cmd_vec_t vecs[8];

  initial begin
    vecs[0] = '{copy:0, desc:0, src:32'h0, dst:32'h0000_A00D, count:16'd4,
                pattern:64'h0720_0720_0720_0720, hold:0, fault_wr:-1, err:0, lat:9};
    vecs[1] = '{copy:1, desc:0, src:32'h100, dst:32'h200, count:16'd3,
                pattern:64'h0, hold:2, fault_wr:-1, err:0, lat:25};
    vecs[2] = '{copy:1, desc:1, src:32'h118, dst:32'h120, count:16'd3,
                pattern:64'h0, hold:0, fault_wr:-1, err:0, lat:13};
    vecs[3] = '{copy:0, desc:0, src:32'h0, dst:32'h800, count:16'd0,
                pattern:64'h1111, hold:0, fault_wr:-1, err:0, lat:1};
    vecs[4] = '{copy:0, desc:0, src:32'h0, dst:32'h1000, count:16'd5,
                pattern:64'hA5A5_5A5A_0F0F_F0F0, hold:0, fault_wr:1, err:1, lat:4};
    vecs[5] = '{copy:0, desc:0, src:32'h0, dst:32'h2000, count:16'd2,
                pattern:64'h0123_4567_89AB_CDEF, hold:1, fault_wr:-1, err:0, lat:7};
    vecs[6] = '{copy:0, desc:0, src:32'h0, dst:32'hFFFF_FFFF, count:16'd2,
                pattern:64'hFEED_0000_0000_BEEF, hold:0, fault_wr:-1, err:0, lat:5};
    vecs[7] = '{copy:0, desc:1, src:32'h0, dst:32'h0000_0003, count:16'd2,
                pattern:64'h0000_CAFE_0000_F00D, hold:0, fault_wr:-1, err:0, lat:5};

    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", 64'(cmdReady), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(donePulse), 64'd0);
    check("rst_err", 64'(errFault), 64'd0);
    check("rst_opm", 64'(bus.busOpm), 64'd0);
    check("rst_addr", 64'(bus.busAddr), 64'd0);
    check("rst_wdata", bus.busOutData, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_cmd(i, vecs[i]);

    // Reset while a copy is waiting in its first read request.
    hold_n   = 100;
    fault_wr = -1;
    wr_seen  = 0;
    @(negedge clock);
    done_cnt = 0;
    cmdCopy  = 1'b1;
    cmdDesc  = 1'b0;
    cmdSrc   = 32'h400;
    cmdDst   = 32'h500;
    cmdCount = 16'd3;
    cmdValid = 1'b1;
    @(posedge clock);
    #1;
    cmdValid = 1'b0;
    check("abort_rd_req", 64'(bus.busOpm), 64'h0B);
    check("abort_busy", 64'(busy), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_opm", 64'(bus.busOpm), 64'd0);
    check("abort_ready", 64'(cmdReady), 64'd1);
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_no_done", 64'(donePulse), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("abort_done_count", 64'(done_cnt), 64'd0);
    check("abort_opm_quiet", 64'(bus.busOpm), 64'd0);
    $display("cmd reset-abort done_count=%0d", done_cnt);

`ifdef TXTBLIT_TIMEOUT_EN
    // Slave stuck at HOLD: 16 cycles in the write request, then abort.
    run_cmd(8, '{copy:0, desc:0, src:32'h0, dst:32'h300, count:16'd2,
                 pattern:64'h7777, hold:100000, fault_wr:0, err:1, lat:17});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
